// File: rtl/ctl_trace_buffer.sv
// Control-vector trace buffer: circular capture with mask/match trigger and post-trigger depth.
// Optional per-entry timestamps when CTL_TRACE_TIMESTAMP_EN is defined.
module ctl_trace_buffer #(
  parameter  int WIDTH    = 62,
  parameter  int DEPTH    = 64,
  parameter  int TS_WIDTH = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    ctl_vec,
  input  logic                ctl_valid,
  input  logic                arm,
  input  logic                change_only,
  input  logic [WIDTH-1:0]    trig_mask,
  input  logic [WIDTH-1:0]    trig_match,
  input  logic [AW-1:0]       post_count,
  output logic [1:0]          state,
  output logic                done,
  output logic [AW-1:0]       wr_ptr,
  output logic [AW-1:0]       trig_ptr,
  output logic [AW:0]         fill,
  input  logic [AW-1:0]       rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic [TS_WIDTH-1:0] rd_ts
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRETRIG  = 2'd1,
    S_POSTTRIG = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_trig_ptr;
  logic [AW-1:0]    r_remaining;
  logic [AW:0]      r_fill;
  logic [WIDTH-1:0] r_last;
  logic             r_first;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_capturing;
  logic w_qual;
  logic w_hit;

  assign w_capturing = (r_state == S_PRETRIG) || (r_state == S_POSTTRIG);
  // The arm cycle itself never captures, so arm masks the qualifier.
  assign w_qual = w_capturing && ctl_valid && !arm &&
                  (!change_only || r_first || (ctl_vec != r_last));
  assign w_hit  = ((ctl_vec ^ trig_match) & trig_mask) == '0;

  always_comb begin
    w_state_next = r_state;
    if (arm) begin
      w_state_next = S_PRETRIG;
    end else begin
      case (r_state)
        S_PRETRIG: begin
          if (w_qual && w_hit) begin
            if (post_count == '0) w_state_next = S_DONE;
            else                  w_state_next = S_POSTTRIG;
          end
        end
        S_POSTTRIG: begin
          if (w_qual && (r_remaining == AW'(1))) w_state_next = S_DONE;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_trig_ptr  <= '0;
      r_remaining <= '0;
      r_fill      <= '0;
      r_last      <= '0;
      r_first     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (arm) begin
        r_wr_ptr <= '0;
        r_fill   <= '0;
        r_first  <= 1'b1;
      end else if (w_qual) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_fill != FILL_MAX) r_fill <= r_fill + (AW+1)'(1);
        r_last  <= ctl_vec;
        r_first <= 1'b0;
        if ((r_state == S_PRETRIG) && w_hit) begin
          r_trig_ptr  <= r_wr_ptr;
          r_remaining <= post_count;
        end else if (r_state == S_POSTTRIG) begin
          r_remaining <= r_remaining - AW'(1);
        end
      end
    end
  end

  // Storage has no reset so it maps onto block RAM; read is read-before-write.
  always_ff @(posedge clk) begin
    if (w_qual) r_mem[r_wr_ptr] <= ctl_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_mem[rd_addr];
  end

`ifdef CTL_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_rd_ts;
  logic [TS_WIDTH-1:0] r_ts_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + TS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (w_qual) r_ts_mem[r_wr_ptr] <= r_ts;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_ts <= '0;
    else       r_rd_ts <= r_ts_mem[rd_addr];
  end

  assign rd_ts = r_rd_ts;
`else
  assign rd_ts = '0;
`endif

  assign state    = r_state;
  assign done     = (r_state == S_DONE);
  assign wr_ptr   = r_wr_ptr;
  assign trig_ptr = r_trig_ptr;
  assign fill     = r_fill;
  assign rd_data  = r_rd_data;

endmodule

// File: doc/ctl_trace_buffer.md
Name: ctl_trace_buffer

Overview:
- Parametrised debug capture block for the 6502 core.
- Samples the packed control-signal vector every qualified cycle into a circular buffer.
- Supports a mask/match trigger with a programmable post-trigger depth, and an optional change-only capture mode.
- Sits beside the decoder and is read out by the bench or debug host after capture, giving control-signal history in hardware rather than only in simulator traces.

Parameters:
WIDTH, 62, width of captured control vector (packed control_signals_t)
DEPTH, 64, buffer entries; power of two, >= 4
TS_WIDTH, 16, timestamp counter width (used only with the optional feature)
(derived) AW = $clog2(DEPTH)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
ctl_vec  in  WIDTH  packed control signals for this cycle
ctl_valid  in  1  sample qualifier (e.g. phi2 tick); ignored in IDLE/DONE
arm  in  1  single-cycle pulse; (re)starts a capture
change_only  in  1  1 = capture only when ctl_vec differs from last captured vector; sampled each cycle
trig_mask  in  WIDTH  trigger compare mask; bits at 0 are don't-care
trig_match  in  WIDTH  trigger compare value
post_count  in  AW  qualifying samples to capture after the trigger sample; latched at trigger
state  out  2  0 IDLE, 1 PRETRIG, 2 POSTTRIG, 3 DONE
done  out  1  high while state == DONE
wr_ptr  out  AW  next write address
trig_ptr  out  AW  address holding the trigger sample
fill  out  AW+1  entries written since arm, saturating at DEPTH
rd_addr  in  AW  absolute read address
rd_data  out  WIDTH  mem[rd_addr], registered, 1-cycle latency
rd_ts  out  TS_WIDTH  timestamp of mem[rd_addr], same latency

Behaviour:
- Reset (async, immediate) values:
  - state = IDLE, done = 0, wr_ptr = 0, trig_ptr = 0, fill = 0.
  - rd_data = 0, rd_ts = 0, timestamp = 0.
  - Last-vector register and first-sample flag are cleared.
  - Memory contents are not reset.
- arm has highest priority, from any state, including mid-capture:
  - Next cycle: state = PRETRIG, wr_ptr = 0, fill = 0, first-sample flag set.
  - The cycle carrying arm performs no capture.
- Qualifying sample: state is PRETRIG or POSTTRIG, ctl_valid = 1, and one of:
  - change_only = 0;
  - the first-sample flag is set;
  - ctl_vec != last captured vector.
- On a qualifying sample:
  - mem[wr_ptr] <= ctl_vec.
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - fill increments, saturating at DEPTH.
  - Last vector <= ctl_vec; first-sample flag cleared.
- PRETRIG -> POSTTRIG:
  - Occurs on a qualifying sample where (ctl_vec & trig_mask) == (trig_match & trig_mask).
  - That sample is written; trig_ptr <= its address.
  - Remaining counter <= post_count.
  - trig_mask = 0 triggers on the first qualifying sample.
  - A non-qualifying cycle never triggers, even if the compare matches.
- PRETRIG -> DONE directly when the trigger sample arrives with post_count = 0.
- POSTTRIG: each qualifying sample is written and decrements remaining. The sample that brings remaining to 0 moves state to DONE in the same edge.
- post_count max is DEPTH-1, so the trigger sample is never overwritten in a single capture.
- DONE: no writes, pointers frozen, done = 1 until the next arm or reset.
- IDLE: no writes; only arm leaves IDLE.
- Read port:
  - Usable in any state.
  - rd_data/rd_ts reflect rd_addr sampled at the previous edge.
  - A read and write to the same address in the same cycle returns the old contents.
- Oldest valid entry: wr_ptr when fill == DEPTH, else 0.
- trig_ptr relative to oldest gives the pre-trigger depth.

Optional Feature:
CTL_TRACE_TIMESTAMP_EN
- Defined:
  - A free-running TS_WIDTH counter increments every clk (wraps), cleared only by reset.
  - Each capture stores the counter value alongside ctl_vec.
  - rd_ts returns the stored value with rd_data latency.
- Undefined:
  - No counter or timestamp storage is built.
  - rd_ts is constant 0.
  - Port list is unchanged.

Test Plan (WIDTH=8, DEPTH=8):
1. Reset mid-POSTTRIG -> same cycle: state=0, done=0, wr_ptr=0, fill=0, rd_data=0; no further writes without arm.
2. arm, mask=0xFF, match=0x5A, post_count=2, ctl_valid=1 every cycle, vec 0x00..0x0F with 0x5A injected after 0x04 -> trig_ptr=5, DONE after the 2 following samples, wr_ptr=0, fill=8; mem[5]=0x5A.
3. arm, mask=0x00, post_count=0 -> trigger and DONE on the first qualifying sample; trig_ptr=0, fill=1, done=1.
4. change_only=1, vec sequence 0x11,0x11,0x22,0x22,0x22,0x11 with ctl_valid=1, no trigger -> entries 0x11,0x22,0x11 only; fill=3, wr_ptr=3.
5. arm, no trigger, 11 qualifying samples 0x01..0x0B -> wr_ptr=3, fill=8; oldest mem[3]=0x04; then arm while PRETRIG -> wr_ptr=0, fill=0, state=PRETRIG next cycle.
6. With CTL_TRACE_TIMESTAMP_EN, capture on cycles 10 and 13 after reset -> rd_ts reads 10 and 13 one cycle after rd_addr. Without the macro, rd_ts = 0 always.
